ula_sequenciador: RTL
=====================

Name: ula_sequenciador

Overview:
Sequencer for the 4-bit ULA datapath. It latches operands from the switches on a start press, then drives the 3-bit operation selector through operations 000..110 (soma, sub, AND, OR, mult, XOR, div). For each operation it samples the ULA result and error flag, and holds each result for display. It sits between the board inputs (SW/KEY) and the existing combinational ULA, replacing direct KEY/SW selector wiring with a timed, step-able schedule.

Parameters:
DWELL_CYCLES, 50000000, auto-mode hold time per operation in clk cycles (1 s at 50 MHz); minimum 2
SYNC_STAGES, 2, flip-flop stages in each button synchronizer; minimum 2
LAST_OP, 6, index of the final operation in the sequence (110 = divisao)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
key_start_n  in  1  start/restart button, active-low, asynchronous to clk
key_step_n  in  1  manual-step button, active-low, asynchronous to clk
auto_mode  in  1  1 = timed advance; 0 = advance on step press
sw_a  in  4  operand A source
sw_b  in  4  operand B source
sw_cin  in  1  carry-in source
alu_result  in  8  ULA mux output (combinational from a_reg/b_reg/cin_reg/seletor)
alu_error  in  1  ULA error flag (LEDR9 source)
a_reg  out  4  latched operand A to ULA
b_reg  out  4  latched operand B to ULA
cin_reg  out  1  latched carry-in to ULA
seletor  out  3  operation select to ULA
result_hold  out  8  last sampled result, to BCD/display path
result_valid  out  1  one-cycle pulse when result_hold updates
err_mask  out  7  bit i set if alu_error was 1 when operation i was sampled
busy  out  1  high in LOAD/SETTLE/SAMPLE/HOLD
done  out  1  high in DONE

Behaviour:
- Reset (async assert, sync release by design of the flops): state IDLE, all outputs 0, dwell counter 0, synchronizers cleared to "released" (1).
- Buttons: each passes through a SYNC_STAGES synchronizer. A press event is a 1-cycle pulse on the synchronized 1->0 edge. Holding the button produces exactly one event. There is no debounce beyond the synchronizer (the board keys are Schmitt-debounced).
- States: IDLE, LOAD, SETTLE, SAMPLE, HOLD, DONE.
- IDLE: seletor=000. A start event goes to LOAD.
- LOAD (1 cycle): a_reg<=sw_a, b_reg<=sw_b, cin_reg<=sw_cin, seletor<=000, err_mask<=0. Go to SETTLE.
- SETTLE (1 cycle): seletor stable; the ULA output settles. Go to SAMPLE.
- SAMPLE (1 cycle): result_hold<=alu_result, err_mask[seletor]<=alu_error, result_valid=1 for this cycle only, dwell counter<=0. Go to HOLD.
- HOLD, auto_mode=1: counter increments each cycle. When it reaches DWELL_CYCLES-1, advance.
- HOLD, auto_mode=0: a step event advances immediately.
- Advance rule: if seletor==LAST_OP, go to DONE; otherwise seletor<=seletor+1 and go to SETTLE. Selector 111 is never driven.
- auto_mode is sampled every HOLD cycle. Switching modes mid-HOLD takes effect on the next cycle, and the counter is not reset.
- DONE: outputs frozen, busy=0, done=1. A start event goes to LOAD.
- Start event in any busy state aborts the sequence: go to LOAD and recapture the switches. Start has priority over step and over dwell expiry in the same cycle.
- Step events outside HOLD, or in HOLD while auto_mode=1, are ignored.
- Switch changes after LOAD do not affect a_reg/b_reg/cin_reg.
- Latency: start press to first result_valid is SYNC_STAGES+1 (edge) + 3 cycles (LOAD, SETTLE, SAMPLE).
- Per-operation period in auto mode is DWELL_CYCLES+2 cycles (SETTLE+SAMPLE+HOLD).
- Reset asserted mid-sequence returns to IDLE within the same cycle (asynchronous); no partial state survives.

Decomposition:
- Shared package: state enum (IDLE..DONE), operation-code constants OP_SOMA=000 .. OP_DIV=110, OP_NONE=111.
- One sub-module, key_sync_edge (SYNC_STAGES parameter; outputs press pulse). It is instantiated twice.

Test Plan:
- Reset then idle: rst_n low for 3 cycles, then high, no keys -> all outputs 0, state IDLE, seletor=000 indefinitely.
- Auto run: DWELL_CYCLES=4, sw_a=3, sw_b=2, sw_cin=0, model ULA, press start -> 7 result_valid pulses 6 cycles apart. seletor steps 000..110; result_hold sequence 5,1,2,3,6,1,1; done=1 after the last pulse.
- Manual mode: auto_mode=0, press start -> one sample at seletor=000. Each step press advances by exactly one op; a step held for 20 cycles advances once.
- Divide by zero: sw_b=0, auto run -> err_mask[6]=1, other bits follow the model's alu_error; sequence still completes to DONE.
- Abort: start pressed during HOLD of op 011 with switches changed to a=9 -> LOAD recaptures a_reg=9, seletor returns to 000, err_mask cleared.
- Async reset mid-HOLD: drop rst_n between clock edges -> outputs 0 immediately. After release, no result_valid until a new start event.

Source files
------------

// File: rtl/ula_sequenciador_pkg.sv
// Shared types and operation codes for the ULA sequencer.
package ula_sequenciador_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_HOLD   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic [2:0] OP_SOMA = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_MULT = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_DIV  = 3'b110;
  localparam logic [2:0] OP_NONE = 3'b111;

  localparam int NUM_OPS = 7;

endpackage

// File: rtl/key_sync_edge.sv
// Synchronizes an active-low asynchronous button and emits a one-cycle
// pulse on the synchronized press (1->0) edge. Holding gives one pulse.
module key_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic press_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchronizer chain plus one delayed copy of the synchronized level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], key_n_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign press_o = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ula_sequenciador.sv
// Steps the ULA selector through every operation, latching operands on
// start and capturing each result and error flag for the display path.
module ula_sequenciador
  import ula_sequenciador_pkg::*;
#(
  parameter int DWELL_CYCLES = 50000000,
  parameter int SYNC_STAGES  = 2,
  parameter int LAST_OP      = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_start_n,
  input  logic       key_step_n,
  input  logic       auto_mode,
  input  logic [3:0] sw_a,
  input  logic [3:0] sw_b,
  input  logic       sw_cin,
  input  logic [7:0] alu_result,
  input  logic       alu_error,
  output logic [3:0] a_reg,
  output logic [3:0] b_reg,
  output logic       cin_reg,
  output logic [2:0] seletor,
  output logic [7:0] result_hold,
  output logic       result_valid,
  output logic [6:0] err_mask,
  output logic       busy,
  output logic       done
);

  localparam int              CNT_W      = $clog2(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [2:0]      LAST_SEL   = 3'(LAST_OP);

  state_t           state_q, state_d;
  logic [3:0]       a_q, a_d, b_q, b_d;
  logic             cin_q, cin_d;
  logic [2:0]       sel_q, sel_d;
  logic [7:0]       hold_q, hold_d;
  logic             valid_q, valid_d;
  logic [6:0]       mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_press, step_press, advance;

  key_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_start_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_n_i (key_start_n),
    .press_o (start_press)
  );

  key_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_step_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_n_i (key_step_n),
    .press_o (step_press)
  );

  // State register together with the operand, result and dwell registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      sel_q   <= OP_SOMA;
      hold_q  <= '0;
      valid_q <= 1'b0;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and register updates; a start press overrides everything.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    sel_d   = sel_q;
    hold_d  = hold_q;
    valid_d = 1'b0;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    advance = 1'b0;
    if (start_press) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_LOAD: begin
          a_d     = sw_a;
          b_d     = sw_b;
          cin_d   = sw_cin;
          sel_d   = OP_SOMA;
          mask_d  = '0;
          state_d = ST_SETTLE;
        end
        ST_SETTLE: state_d = ST_SAMPLE;
        ST_SAMPLE: begin
          hold_d  = alu_result;
          valid_d = 1'b1;
          cnt_d   = '0;
          for (int i = 0; i < NUM_OPS; i++) begin
            if (sel_q == 3'(i)) mask_d[i] = alu_error;
          end
          state_d = ST_HOLD;
        end
        ST_HOLD: begin
          if (auto_mode) begin
            if (cnt_q == DWELL_LAST) advance = 1'b1;
            else                     cnt_d   = cnt_q + CNT_W'(1);
          end else if (step_press) begin
            advance = 1'b1;
          end
          if (advance) begin
            if (sel_q == LAST_SEL) begin
              state_d = ST_DONE;
            end else begin
              sel_d   = sel_q + 3'd1;
              state_d = ST_SETTLE;
            end
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Status flags decoded from the current state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_LOAD, ST_SETTLE, ST_SAMPLE, ST_HOLD: busy = 1'b1;
      ST_DONE:                                done = 1'b1;
      default:                                busy = 1'b0;
    endcase
  end

  assign a_reg        = a_q;
  assign b_reg        = b_q;
  assign cin_reg      = cin_q;
  assign seletor      = sel_q;
  assign result_hold  = hold_q;
  assign result_valid = valid_q;
  assign err_mask     = mask_q;

endmodule
